// File: rtl/uart_tx_arbiter_if.sv
// FIFO-side and UART-side signal bundle for the UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            f_empty;
  logic [NUM_CH*DATA_WIDTH-1:0] fifo_read_data;
  logic [NUM_CH-1:0]            fifo_read_en;
  logic                         uart_tx_done;
  logic                         uart_dv;
  logic [DATA_WIDTH-1:0]        uart_data;
  logic [CH_W-1:0]              active_ch;
  logic                         busy;
  logic                         timeout_err;

  modport master (
    input  ch_enable, f_empty, fifo_read_data, uart_tx_done,
    output fifo_read_en, uart_dv, uart_data, active_ch, busy, timeout_err
  );

  modport slave (
    output ch_enable, f_empty, fifo_read_data, uart_tx_done,
    input  fifo_read_en, uart_dv, uart_data, active_ch, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_CH byte FIFOs,
// with bursts of up to MAX_BURST bytes per grant and an acknowledge timeout.
module uart_tx_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_BURST   = 4,
  parameter int ACK_TIMEOUT = 200000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TM_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TM_W-1:0] TIMER_LAST = TM_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_LOAD, S_ACK} state_t;

  state_t                state_q, state_d;
  logic [NUM_CH-1:0]     fifo_read_en_q, fifo_read_en_d;
  logic                  uart_dv_q, uart_dv_d;
  logic [DATA_WIDTH-1:0] uart_data_q, uart_data_d;
  logic [CH_W-1:0]       active_ch_q, active_ch_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
  logic [TM_W-1:0]       timer_q, timer_d;

  logic [NUM_CH-1:0]     eligible;
  logic                  grant_found;
  logic [CH_W-1:0]       grant_ch;
  logic [CH_W-1:0]       next_ptr;
  logic                  burst_more;
  logic [DATA_WIDTH-1:0] fifo_words [NUM_CH];
  int                    cand;

  assign eligible   = bus.ch_enable & ~bus.f_empty;
  assign next_ptr   = (int'(active_ch_q) == NUM_CH - 1) ? '0 : active_ch_q + 1'b1;
  assign burst_more = (int'(burst_cnt_q) + 1 < MAX_BURST) && eligible[active_ch_q];

  // Split the flat read-data bus into per-channel words.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_words[i] = bus.fifo_read_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First eligible channel at or after the round-robin pointer, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    cand        = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!grant_found && eligible[CH_W'(cand)]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'(cand);
      end
    end
  end

  // Next-state and registered-output logic of the grant/pop/send/ack sequence.
  always_comb begin
    state_d        = state_q;
    fifo_read_en_d = '0;
    uart_dv_d      = 1'b0;
    uart_data_d    = '0;
    active_ch_d    = active_ch_q;
    timeout_err_d  = 1'b0;
    rr_ptr_d       = rr_ptr_q;
    burst_cnt_d    = burst_cnt_q;
    timer_d        = timer_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          fifo_read_en_d[grant_ch] = 1'b1;
          active_ch_d              = grant_ch;
          burst_cnt_d              = '0;
          state_d                  = S_READ;
        end
      end
      S_READ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // FIFO data is valid now, one cycle after the pop strobe.
        uart_data_d = fifo_words[active_ch_q];
        uart_dv_d   = 1'b1;
        timer_d     = '0;
        state_d     = S_ACK;
      end
      S_ACK: begin
        timer_d = timer_q + 1'b1;
        // A done pulse coincident with our own data-valid belongs to an older frame.
        if (bus.uart_tx_done && !uart_dv_q) begin
          if (burst_more) begin
            burst_cnt_d                 = burst_cnt_q + 1'b1;
            fifo_read_en_d[active_ch_q] = 1'b1;
            state_d                     = S_READ;
          end else begin
            rr_ptr_d = next_ptr;
            state_d  = S_IDLE;
          end
        end else if (timer_q == TIMER_LAST) begin
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      fifo_read_en_q <= '0;
      uart_dv_q      <= 1'b0;
      uart_data_q    <= '0;
      active_ch_q    <= '0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      rr_ptr_q       <= '0;
      burst_cnt_q    <= '0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      fifo_read_en_q <= fifo_read_en_d;
      uart_dv_q      <= uart_dv_d;
      uart_data_q    <= uart_data_d;
      active_ch_q    <= active_ch_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      rr_ptr_q       <= rr_ptr_d;
      burst_cnt_q    <= burst_cnt_d;
      timer_q        <= timer_d;
    end
  end

  assign bus.fifo_read_en = fifo_read_en_q;
  assign bus.uart_dv      = uart_dv_q;
  assign bus.uart_data    = uart_data_q;
  assign bus.active_ch    = active_ch_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: FIFO and UART models, a transaction-level
// reference model of the arbitration rules, and an independent output monitor.
module tb_uart_tx_arbiter;
  localparam int NUM_CH      = 4;
  localparam int DW          = 8;
  localparam int MAX_BURST   = 4;
  localparam int ACK_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST),
                    .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed { int cyc; logic [7:0] data; } dv_t;
  typedef struct packed { logic [3:0] rden; logic busy; logic [1:0] act; logic terr; } cyc_exp_t;
  typedef logic [7:0] bq_t [$];

  dv_t        exp_q [$];
  cyc_exp_t   exp_cyc [int];
  bq_t        fifo [NUM_CH];
  logic [7:0] dv_log [$];
  int cyc = 0, total = 0, bad = 0, terr_seen = 0;

  // reference model state
  bit m_active = 0;
  int m_dv = 0, m_ch = 0, m_burst = 0, m_ptr = 0, m_done_at = -1;
  // stimulus configuration
  logic [3:0] en_cfg = 4'b0000;
  bit rst_cfg = 1, force_done = 0, stray_en = 0, rand_push = 0;
  int done_delay = 3;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int pick_done_at(int dv);
    if (done_delay == -1) return -1;
    if (done_delay == -2) return ($urandom_range(0, 7) == 0) ? -1 : dv + int'($urandom_range(0, 8));
    return dv + done_delay;
  endfunction

  task automatic issue_byte();
    dv_t d;
    d.cyc = cyc + 3;
    d.data = fifo[m_ch][0];
    exp_q.push_back(d);
    m_dv = cyc + 3;
    m_done_at = pick_done_at(m_dv);
  endtask

  // Reference model: given this cycle's inputs, predict next cycle's outputs.
  task automatic model_step(logic [3:0] elig, logic done);
    cyc_exp_t e;
    e.rden = '0;
    e.terr = 1'b0;
    if (rst_cfg) begin
      m_active = 0; m_ptr = 0; m_ch = 0; m_burst = 0;
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      e.busy = 1'b0; e.act = '0;
      exp_cyc[cyc+1] = e;
      return;
    end
    if (!m_active) begin
      if (elig != 0) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (elig[(m_ptr + k) % NUM_CH]) begin m_ch = (m_ptr + k) % NUM_CH; break; end
        end
        m_active = 1; m_burst = 0;
        e.rden[m_ch] = 1'b1;
        issue_byte();
      end
    end else if (cyc >= m_dv) begin
      if (done && cyc > m_dv) begin
        if (m_burst + 1 < MAX_BURST && elig[m_ch]) begin
          m_burst++;
          e.rden[m_ch] = 1'b1;
          issue_byte();
        end else begin
          m_ptr = (m_ch + 1) % NUM_CH; m_active = 0;
        end
      end else if (cyc - m_dv == ACK_TIMEOUT - 1) begin
        e.terr = 1'b1; m_ptr = (m_ch + 1) % NUM_CH; m_active = 0;
      end
    end
    e.busy = m_active;
    e.act  = 2'(m_ch);
    exp_cyc[cyc+1] = e;
  endtask

  // One clock: FIFO pop bookkeeping, stimulus drive, then model prediction.
  task automatic step();
    logic [3:0]  rs, fe;
    logic [31:0] rd;
    logic        done;
    @(negedge clk);
    rs = bus.fifo_read_en;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      rd[i*8 +: 8] = 8'($urandom);
      if (rs[i] === 1'b1 && fifo[i].size() > 0) rd[i*8 +: 8] = fifo[i].pop_front();
    end
    if (rand_push && $urandom_range(0, 5) == 0) fifo[$urandom_range(0, NUM_CH-1)].push_back(8'($urandom));
    for (int i = 0; i < NUM_CH; i++) fe[i] = (fifo[i].size() == 0);
    done = force_done || (m_active && cyc == m_done_at) || (stray_en && $urandom_range(0, 29) == 0);
    rst                = rst_cfg;
    bus.ch_enable      = en_cfg;
    bus.f_empty        = fe;
    bus.fifo_read_data = rd;
    bus.uart_tx_done   = done;
    model_step(en_cfg & ~fe, done);
  endtask

  function automatic bit pending();
    logic [3:0] ne;
    for (int i = 0; i < NUM_CH; i++) ne[i] = (fifo[i].size() != 0);
    return m_active || ((en_cfg & ne) != 0);
  endfunction

  task automatic drain(string name, int maxc);
    int n = 0;
    while (pending() && n < maxc) begin step(); n++; end
    chk({"drain_", name}, 32'(n < maxc), 1);
    repeat (3) step();
  endtask

  // Monitor: compares every cycle's registered outputs against the model.
  initial begin
    cyc_exp_t e;
    dv_t d;
    forever begin
      @(negedge clk);
      if (cyc < 2) continue;
      if (exp_cyc.exists(cyc)) begin
        e = exp_cyc[cyc];
        chk("fifo_read_en", 32'(bus.fifo_read_en), 32'(e.rden));
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("active_ch", 32'(bus.active_ch), 32'(e.act));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e.terr));
        exp_cyc.delete(cyc);
      end
      for (int i = 0; i < NUM_CH; i++)
        if (bus.fifo_read_en[i] === 1'b1) chk("pop_nonempty", 32'(fifo[i].size() > 0), 1);
      if (bus.timeout_err === 1'b1) terr_seen++;
      if (bus.uart_dv === 1'b1) begin
        chk("dv_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          d = exp_q.pop_front();
          chk("dv_cycle", cyc, d.cyc);
          chk("uart_data", 32'(bus.uart_data), 32'(d.data));
        end
        dv_log.push_back(bus.uart_data);
      end else begin
        chk("uart_data_idle", 32'(bus.uart_data), 0);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk("dv_missing_cycle", cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int ls;
    int n;
    logic [7:0] want [$];
    bus.ch_enable = '0; bus.f_empty = '1; bus.fifo_read_data = '0; bus.uart_tx_done = 1'b0;

    // reset
    rst_cfg = 1; repeat (3) step();
    rst_cfg = 0; repeat (3) step();

    // single channel, done 10 cycles after dv
    en_cfg = 4'b0001; done_delay = 10; ls = dv_log.size();
    fifo[0].push_back(8'hA5);
    drain("single", 200);
    chk("single_count", dv_log.size() - ls, 1);
    chk("single_data", 32'(dv_log[ls]), 32'hA5);

    // round robin, 8 bytes per channel
    en_cfg = 4'b1111; done_delay = 3; ls = dv_log.size();
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < 8; j++) fifo[c].push_back(8'(c*16 + j));
    drain("rr", 2000);
    want.delete();
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < MAX_BURST; j++) want.push_back(8'(((1 + g) % NUM_CH) * 16 + (g / 4) * 4 + j));
    chk("rr_count", dv_log.size() - ls, 32);
    for (int i = 0; i < want.size(); i++) chk("rr_order", 32'(dv_log[ls+i]), 32'(want[i]));

    // burst interleave ch1/ch2
    en_cfg = 4'b0110; ls = dv_log.size();
    for (int j = 0; j < 6; j++) fifo[1].push_back(8'(8'h10 + j));
    fifo[2].push_back(8'h20); fifo[2].push_back(8'h21);
    drain("burst", 500);
    want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h14, 8'h15};
    for (int i = 0; i < want.size(); i++) chk("burst_order", 32'(dv_log[ls+i]), 32'(want[i]));

    // reset during ACK of the 2nd byte of a burst
    en_cfg = 4'b0011; done_delay = 4; ls = dv_log.size();
    for (int j = 0; j < 4; j++) fifo[0].push_back(8'(8'h50 + j));
    fifo[1].push_back(8'h60); fifo[1].push_back(8'h61);
    n = 0;
    while (!(m_active && m_burst == 1 && cyc > m_dv) && n < 100) begin step(); n++; end
    chk("rst_trigger_reached", 32'(n < 100), 1);
    rst_cfg = 1; step(); rst_cfg = 0;
    drain("rst_mid", 500);
    want = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61};
    for (int i = 0; i < want.size(); i++) chk("rst_order", 32'(dv_log[ls+i]), 32'(want[i]));

    // burst cut by empty FIFO
    rst_cfg = 1; repeat (2) step(); rst_cfg = 0;
    en_cfg = 4'b1001; done_delay = 2; ls = dv_log.size();
    fifo[0].push_back(8'h30); fifo[0].push_back(8'h31); fifo[3].push_back(8'h3F);
    drain("cut", 300);
    want = '{8'h30, 8'h31, 8'h3F};
    for (int i = 0; i < want.size(); i++) chk("cut_order", 32'(dv_log[ls+i]), 32'(want[i]));

    // acknowledge timeout, then a stray done while idle
    en_cfg = 4'b0011; done_delay = -1; n = terr_seen;
    fifo[0].push_back(8'h70); fifo[1].push_back(8'h71);
    drain("timeout", 300);
    chk("timeout_pulses", terr_seen - n, 2);
    force_done = 1; step(); force_done = 0;
    repeat (3) step();
    done_delay = 2; ls = dv_log.size();
    fifo[1].push_back(8'h72);
    drain("after_stray", 100);
    chk("after_stray_data", 32'(dv_log[ls]), 32'h72);

    // randomized traffic: enables, pushes, done timing, stray dones, resets
    rand_push = 1; stray_en = 1; done_delay = -2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) en_cfg = 4'($urandom);
      rst_cfg = ($urandom_range(0, 699) == 0);
      step();
    end
    rst_cfg = 0; rand_push = 0; stray_en = 0; done_delay = 3; en_cfg = 4'b1111;
    drain("final", 3000);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
